multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//   Moore FSM that drives every control input of the multicycle MIPS Data_Path from OP/Funct and the ALU zero flag.
//   Sits beside Data_Path at the top level, replacing hand-driven control. Supports R-type, lw, sw, beq, bne, addi and optional j.
//   Also provides an instruction counter, a state monitor and an illegal-opcode flag.
// PARAMETERS
//   ALU_CTRL_WIDTH  4   ALUControl width. Codes are zero-extended into this width.
//   COUNT_WIDTH     16  width of the retired-fetch counter
// PORTS
//   clk            in   1                clock, rising edge
//   reset          in   1                asynchronous, active-low reset
//   OP             in   6                IR[31:26]
//   Funct          in   6                IR[5:0]
//   Zero           in   1                ALU zero flag
//   PCWrite        out  1                PC enable: state PCWrite | (Branch & taken)
//   IorD           out  1                0=PC address, 1=ALUOut address
//   MemWrite       out  1                memory write
//   IRWrite        out  1                IR load
//   RegDst         out  1                0=rt, 1=rd
//   MemtoReg       out  1                0=ALUOut, 1=Data
//   RegWrite       out  1                register file write
//   ALUSrcA        out  1                0=PC, 1=A
//   ALUSrcB        out  2                00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   ALUControl     out  ALU_CTRL_WIDTH   AND=0000 OR=0001 NOR=0010 ADD=0100 SUB=0101 SLT=0110 SLL=1000 SRL=1001
//   PCSrc          out  2                00=ALUResult, 01=ALUOut, 10=jump target
//   state_o        out  4                current state encoding, listed below
//   instr_count_o  out  COUNT_WIDTH      number of FETCH cycles since reset; wraps
//   illegal_o      out  1                unsupported OP/Funct detected in DECODE
// BEHAVIOUR
//   States: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMREAD=4 MEMWB=5 MEMWRITE=6 EXECUTE=7 ALUWB=8 BRANCH=9 ADDIEX=10 ADDIWB=11 JUMP=12.
//   Reset (reset=0): state=IDLE and instr_count_o=0; all outputs 0. Mid-instruction reset aborts immediately, with no partial writes.
//   IDLE -> FETCH unconditionally; this is the first cycle after reset release.
//   Outputs are decoded from state only, except PCWrite (uses Zero) and illegal_o. Any output not listed for a state is 0.
//   FETCH: IorD=0 SrcA=0 SrcB=01 ADD PCSrc=00 IRWrite=1 PCWrite=1; instr_count_o+1 at the clock edge leaving FETCH.
//   DECODE: SrcA=0 SrcB=11 ADD (branch target into ALUOut). Next state by OP:
//     000000->EXECUTE; 100011/101011->MEMADR; 000100/000101->BRANCH; 001000->ADDIEX; 000010->JUMP (see CONFIGURATION).
//     Otherwise illegal_o=1 this cycle, then FETCH.
//   R-type Funct legal set: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 000000 sll, 000010 srl.
//     Other Funct: illegal_o=1 in DECODE, then FETCH.
//   MEMADR: SrcA=1 SrcB=10 ADD. Next state: lw->MEMREAD, sw->MEMWRITE.
//   MEMREAD: IorD=1 -> MEMWB.   MEMWB: RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH.
//   MEMWRITE: IorD=1 MemWrite=1 -> FETCH.
//   EXECUTE: SrcA=1 SrcB=00, ALUControl from Funct -> ALUWB.   ALUWB: RegDst=1 MemtoReg=0 RegWrite=1 -> FETCH.
//   BRANCH: SrcA=1 SrcB=00 SUB PCSrc=01; taken = Zero for beq, ~Zero for bne; PCWrite=taken -> FETCH.
//   ADDIEX: SrcA=1 SrcB=10 ADD -> ADDIWB.   ADDIWB: RegDst=0 MemtoReg=0 RegWrite=1 -> FETCH.
//   JUMP: PCSrc=10 PCWrite=1 -> FETCH.
//   Latency in cycles, FETCH inclusive: lw 5; sw 4; R 4; addi 4; beq/bne 3; j 3; illegal 2.
//   instr_count_o wraps from 2^COUNT_WIDTH-1 to 0 with no flag. Unused encodings 13-15 -> FETCH on the next edge, outputs 0.
// CONFIGURATION
//   MCU_JUMP_EN defined: OP=000010 -> JUMP state as above.
//   MCU_JUMP_EN undefined: no JUMP state; OP=000010 is illegal (illegal_o=1, -> FETCH); PCSrc never equals 10.
// TESTING
//   1 reset=0 for 3 cycles, then release -> all outputs 0, state_o=0; next cycle state_o=1 with PCWrite=IRWrite=1.
//   2 lw (OP=100011) -> states 1,2,3,4,5, then 1; MEMWB shows MemtoReg=1 RegWrite=1; instr_count_o 0->1.
//   3 R sub (Funct=100010) -> EXECUTE ALUControl=0101; ALUWB RegDst=1 RegWrite=1. Funct=111111 -> illegal_o=1 in DECODE.
//   4 beq Zero=1 -> PCWrite=1 PCSrc=01 in BRANCH; beq Zero=0 -> PCWrite=0; bne Zero=0 -> PCWrite=1.
//   5 OP=111111 -> illegal_o=1 for 1 cycle, back to FETCH, no RegWrite/MemWrite; reset asserted in MEMREAD -> outputs 0 immediately.
//   6 COUNT_WIDTH=2, 5 instructions -> instr_count_o 1,2,3,0,1. OP=000010: with MCU_JUMP_EN -> PCSrc=10, else illegal_o=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore control FSM for the multicycle MIPS data path. It decodes OP/Funct
//   into the per-state control word. It also counts FETCH cycles and flags
//   unsupported opcodes or functions while the FSM is in DECODE.
//   Optional feature macro: MCU_JUMP_EN. When it is defined, OP=000010 (j)
//   is executed through the JUMP state. When it is not defined, OP=000010 is
//   treated as an illegal opcode.
//
//   state     | meaning
//   IDLE     0| first cycle after reset release, outputs quiet
//   FETCH    1| read instruction at PC, IR load, PC <= PC+4
//   DECODE   2| register read, branch target into ALUOut, opcode dispatch
//   MEMADR   3| lw/sw effective address A+SignImm
//   MEMREAD  4| data memory read at ALUOut
//   MEMWB    5| loaded data written to rt
//   MEMWRITE 6| B stored at ALUOut
//   EXECUTE  7| R-type ALU operation on A,B
//   ALUWB    8| R-type result written to rd
//   BRANCH   9| compare A,B; PC <= ALUOut when the branch is taken
//   ADDIEX  10| A+SignImm
//   ADDIWB  11| addi result written to rt
//   JUMP    12| PC <= jump target (MCU_JUMP_EN only)
module multicycle_control_unit #(
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                OP,
  input  logic [5:0]                Funct,
  input  logic                      Zero,
  output logic                      PCWrite,
  output logic                      IorD,
  output logic                      MemWrite,
  output logic                      IRWrite,
  output logic                      RegDst,
  output logic                      MemtoReg,
  output logic                      RegWrite,
  output logic                      ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [1:0]                PCSrc,
  output logic [3:0]                state_o,
  output logic [COUNT_WIDTH-1:0]    instr_count_o,
  output logic                      illegal_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
`ifdef MCU_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MCU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       funct_legal;
  logic [3:0] funct_alu;
  logic       op_legal;
  logic       branch_taken;
  logic       pc_write_state;
  logic       branch_state;
  logic [3:0] alu_code;

  // R-type function decode: legality and the ALU operation it selects
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_AND;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_NOR:  funct_alu = ALU_NOR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_SLL:  funct_alu = ALU_SLL;
      FN_SRL:  funct_alu = ALU_SRL;
      default: funct_legal = 1'b0;
    endcase
  end

  // Opcode legality; an R-type opcode also needs a supported function
  always_comb begin
    op_legal = 1'b0;
    case (OP)
      OP_RTYPE:                              op_legal = funct_legal;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI: op_legal = 1'b1;
`ifdef MCU_JUMP_EN
      OP_J:                                  op_legal = 1'b1;
`endif
      default:                               op_legal = 1'b0;
    endcase
  end

  // Next-state logic; illegal instructions fall straight back to FETCH
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (op_legal) begin
          case (OP)
            OP_RTYPE:       next_state = S_EXECUTE;
            OP_LW, OP_SW:   next_state = S_MEMADR;
            OP_BEQ, OP_BNE: next_state = S_BRANCH;
            OP_ADDI:        next_state = S_ADDIEX;
`ifdef MCU_JUMP_EN
            OP_J:           next_state = S_JUMP;
`endif
            default:        next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   next_state = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEX:   next_state = S_ADDIWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // State register; an abort by reset leaves every control output quiet at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Retired-fetch counter, bumped on the edge that leaves FETCH, wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                instr_count_o <= '0;
    else if (state == S_FETCH) instr_count_o <= instr_count_o + COUNT_WIDTH'(1);
  end

  // Moore control word; only PCWrite (branch outcome) and illegal_o look at inputs
  always_comb begin
    pc_write_state = 1'b0;
    branch_state   = 1'b0;
    IorD           = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    RegDst         = 1'b0;
    MemtoReg       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    alu_code       = 4'b0000;
    PCSrc          = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB        = 2'b01;
        alu_code       = ALU_ADD;
        IRWrite        = 1'b1;
        pc_write_state = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB  = 2'b11;
        alu_code = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        alu_code = ALU_ADD;
      end
      S_MEMREAD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA  = 1'b1;
        alu_code = funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        alu_code     = ALU_SUB;
        PCSrc        = 2'b01;
        branch_state = 1'b1;
      end
      S_ADDIWB:   RegWrite = 1'b1;
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        PCSrc          = 2'b10;
        pc_write_state = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // beq is taken on Zero, bne on not-Zero; only meaningful inside BRANCH
  assign branch_taken = (OP == OP_BNE) ? ~Zero : Zero;
  assign PCWrite      = pc_write_state | (branch_state & branch_taken);
  assign ALUControl   = ALU_CTRL_WIDTH'(alu_code);
  assign illegal_o    = (state == S_DECODE) & ~op_legal;
  assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit, built with COUNT_WIDTH=2 so the
// fetch counter wraps quickly. Observed word = {state_o, control outputs}.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [1:0] PCSrc;
  logic [3:0] state_o;
  logic [1:0] instr_count_o;
  logic       illegal_o;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_cnt;

  multicycle_control_unit #(.ALU_CTRL_WIDTH(4), .COUNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .state_o(state_o),
    .instr_count_o(instr_count_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal}
  logic [20:0] obs;
  assign obs = {state_o, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal_o};

  localparam logic [20:0] E_IDLE    = {4'd0,  8'b0000_0000, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_FETCH   = {4'd1,  8'b1001_0000, 2'b01, 4'b0100, 2'b00, 1'b0};
  localparam logic [20:0] E_DEC     = {4'd2,  8'b0000_0000, 2'b11, 4'b0100, 2'b00, 1'b0};
  localparam logic [20:0] E_DEC_ILL = {4'd2,  8'b0000_0000, 2'b11, 4'b0100, 2'b00, 1'b1};
  localparam logic [20:0] E_MEMADR  = {4'd3,  8'b0000_0001, 2'b10, 4'b0100, 2'b00, 1'b0};
  localparam logic [20:0] E_MEMRD   = {4'd4,  8'b0100_0000, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_MEMWB   = {4'd5,  8'b0000_0110, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_MEMWR   = {4'd6,  8'b0110_0000, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_EX_SUB  = {4'd7,  8'b0000_0001, 2'b00, 4'b0101, 2'b00, 1'b0};
  localparam logic [20:0] E_EX_SLT  = {4'd7,  8'b0000_0001, 2'b00, 4'b0110, 2'b00, 1'b0};
  localparam logic [20:0] E_EX_SRL  = {4'd7,  8'b0000_0001, 2'b00, 4'b1001, 2'b00, 1'b0};
  localparam logic [20:0] E_EX_NOR  = {4'd7,  8'b0000_0001, 2'b00, 4'b0010, 2'b00, 1'b0};
  localparam logic [20:0] E_ALUWB   = {4'd8,  8'b0000_1010, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_BR_T    = {4'd9,  8'b1000_0001, 2'b00, 4'b0101, 2'b01, 1'b0};
  localparam logic [20:0] E_BR_N    = {4'd9,  8'b0000_0001, 2'b00, 4'b0101, 2'b01, 1'b0};
  localparam logic [20:0] E_ADDIEX  = {4'd10, 8'b0000_0001, 2'b10, 4'b0100, 2'b00, 1'b0};
  localparam logic [20:0] E_ADDIWB  = {4'd11, 8'b0000_0010, 2'b00, 4'b0000, 2'b00, 1'b0};
  localparam logic [20:0] E_JUMP    = {4'd12, 8'b1000_0000, 2'b00, 4'b0000, 2'b10, 1'b0};

  task automatic test_reset();
    reset = 1'b0; OP = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL reset_word: got %h expected %h", obs, E_IDLE);
    end
    checks++;
    if (instr_count_o !== 2'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", instr_count_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL release_idle: got %h expected %h", obs, E_IDLE);
    end
    @(negedge clk);
    exp_cnt = 2'd0;
  endtask

  task automatic test_lw();
    logic [20:0] seq [5] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB};
    OP = 6'b100011; Funct = 6'b111111; Zero = 1'b1;
    checks++;
    if (instr_count_o !== exp_cnt) begin
      errors++; $display("FAIL lw_count: got %0d expected %0d", instr_count_o, exp_cnt);
    end
    exp_cnt++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL lw_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [20:0] seq [4] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMWR};
    OP = 6'b101011; Funct = 6'd0; Zero = 1'b0;
    checks++;
    if (instr_count_o !== exp_cnt) begin
      errors++; $display("FAIL sw_count: got %0d expected %0d", instr_count_o, exp_cnt);
    end
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL sw_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [4] = '{6'b100010, 6'b101010, 6'b000010, 6'b100111};
    logic [20:0] ex [4] = '{E_EX_SUB, E_EX_SLT, E_EX_SRL, E_EX_NOR};
    logic [20:0] seq [4];
    for (int k = 0; k < 4; k++) begin
      OP = 6'b000000; Funct = fn[k]; Zero = 1'b0;
      seq = '{E_FETCH, E_DEC, ex[k], E_ALUWB};
      checks++;
      if (instr_count_o !== exp_cnt) begin
        errors++; $display("FAIL rtype%0d_count: got %0d expected %0d", k, instr_count_o, exp_cnt);
      end
      exp_cnt++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          errors++; $display("FAIL rtype%0d_step%0d: got %h expected %h", k, i, obs, seq[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal_funct();
    logic [20:0] seq [3] = '{E_FETCH, E_DEC_ILL, E_FETCH};
    OP = 6'b000000; Funct = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL bad_funct_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 2) @(negedge clk);
    end
    exp_cnt++;
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic        zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [20:0] br  [4] = '{E_BR_T, E_BR_N, E_BR_T, E_BR_N};
    logic [20:0] seq [3];
    for (int k = 0; k < 4; k++) begin
      OP = ops[k]; Funct = 6'd0; Zero = zs[k];
      seq = '{E_FETCH, E_DEC, br[k]};
      exp_cnt++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          errors++; $display("FAIL branch%0d_step%0d: got %h expected %h", k, i, obs, seq[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_addi();
    logic [20:0] seq [4] = '{E_FETCH, E_DEC, E_ADDIEX, E_ADDIWB};
    OP = 6'b001000; Funct = 6'd0; Zero = 1'b0;
    checks++;
    if (instr_count_o !== exp_cnt) begin
      errors++; $display("FAIL addi_count: got %0d expected %0d", instr_count_o, exp_cnt);
    end
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL addi_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
`ifdef MCU_JUMP_EN
    logic [20:0] seq [3] = '{E_FETCH, E_DEC, E_JUMP};
    localparam int N = 3;
`else
    logic [20:0] seq [2] = '{E_FETCH, E_DEC_ILL};
    localparam int N = 2;
`endif
    OP = 6'b000010; Funct = 6'd0;
    exp_cnt++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL jump_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_op();
    logic [20:0] seq [3] = '{E_FETCH, E_DEC_ILL, E_FETCH};
    OP = 6'b111111; Funct = 6'b100000;
    checks++;
    if (instr_count_o !== exp_cnt) begin
      errors++; $display("FAIL bad_op_count: got %0d expected %0d", instr_count_o, exp_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL bad_op_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 2) @(negedge clk);
    end
    exp_cnt++;
  endtask

  task automatic test_reset_midinstr();
    logic [20:0] seq [4] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD};
    OP = 6'b100011; Funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL abort_step%0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 3) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL abort_word: got %h expected %h", obs, E_IDLE);
    end
    checks++;
    if (instr_count_o !== 2'd0) begin
      errors++; $display("FAIL abort_count: got %0d expected 0", instr_count_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_cnt = 2'd0;
  endtask

  task automatic test_count_wrap();
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    OP = 6'b111111; Funct = 6'd0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (obs !== E_FETCH) begin
        errors++; $display("FAIL wrap%0d_fetch: got %h expected %h", n, obs, E_FETCH);
      end
      @(negedge clk);
      checks++;
      if (instr_count_o !== cnt_exp[n]) begin
        errors++; $display("FAIL wrap%0d_count: got %0d expected %0d", n, instr_count_o, cnt_exp[n]);
      end
      @(negedge clk);
    end
    exp_cnt = 2'd1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_illegal_funct();
    test_branch();
    test_addi();
    test_jump();
    test_illegal_op();
    test_reset_midinstr();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
